fifo_wr_arb: RTL and testbench

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_wr_arb.sv | 186 ++++++++++++++++++
 tb/tb_fifo_wr_arb.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin write arbiter that funnels NREQ requester beat
// streams into a single FIFO write port through a one-entry output register.
//
// Optional feature macro: FIFO_ARB_BURST_EN
//   undefined (default): the winner is re-arbitrated on every beat.
//   defined: a winner is locked in (IDLE/LOCK FSM) for up to BURST_LEN beats.
//
// Ports
//   clk       : single clock for all logic
//   rst_n     : asynchronous active-low reset
//   req       : [NREQ] per-requester "beat available" flag
//   req_data  : [NREQ*DATA_W] requester i's beat at [i*DATA_W +: DATA_W]
//   gnt       : [NREQ] combinational one-hot accept strobe (req[i] & gnt[i] = transfer)
//   full      : FIFO full flag
//   w_valid   : FIFO write strobe (registered)
//   w_data    : [DATA_W] FIFO write data (registered)

module fifo_wr_arb #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        gnt,
  input  logic                   full,
  output logic                   w_valid,
  output logic [DATA_W-1:0]      w_data
);

  localparam int unsigned PTR_W = $clog2(NREQ);
  localparam int unsigned SUM_W = PTR_W + 1;

  // Elaboration-time guard on the supported parameter range.
  if (NREQ < 2 || NREQ > 8 || BURST_LEN < 2 || BURST_LEN > 16) begin : g_cfg_check
    $error("fifo_wr_arb: unsupported NREQ/BURST_LEN");
  end

  logic              free_c;
  logic [PTR_W-1:0]  ptr, ptr_nxt;
  logic [PTR_W-1:0]  rr_win_c;
  logic              rr_hit_c;
  logic [PTR_W-1:0]  win_c;
  logic              grant_c;
  logic [DATA_W-1:0] beat_c;
  logic              w_valid_nxt;
  logic [DATA_W-1:0] w_data_nxt;

`ifdef FIFO_ARB_BURST_EN
  localparam int unsigned CNT_W = $clog2(BURST_LEN) + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  owner, owner_nxt;
  logic [CNT_W-1:0]  burst_cnt, cnt_nxt;
`endif

  // Pointer successor with wrap from NREQ-1 back to 0.
  function automatic logic [PTR_W-1:0] next_of(input logic [PTR_W-1:0] w);
    return (w == PTR_W'(NREQ - 1)) ? '0 : w + PTR_W'(1);
  endfunction

  // Output register can take a new beat if empty or being drained this cycle;
  // gated by rst_n so no grant is ever shown while reset is asserted.
  assign free_c = rst_n && (!w_valid || !full);

  // Round-robin search: first requester at or above ptr, wrapping.
  always_comb begin
    logic [SUM_W-1:0] sum;
    rr_hit_c = 1'b0;
    rr_win_c = '0;
    sum      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + SUM_W'(k);
      if (sum >= SUM_W'(NREQ)) sum = sum - SUM_W'(NREQ);
      if (!rr_hit_c && req[sum[PTR_W-1:0]]) begin
        rr_hit_c = 1'b1;
        rr_win_c = sum[PTR_W-1:0];
      end
    end
  end

  // Grant decision, pointer update and (optional) burst-lock FSM.
  always_comb begin
    grant_c = 1'b0;
    win_c   = rr_win_c;
    ptr_nxt = ptr;
`ifdef FIFO_ARB_BURST_EN
    state_nxt = state;
    owner_nxt = owner;
    cnt_nxt   = burst_cnt;
    case (state)
      IDLE: begin
        if (free_c && rr_hit_c) begin
          grant_c   = 1'b1;
          ptr_nxt   = next_of(rr_win_c);
          state_nxt = LOCK;
          owner_nxt = rr_win_c;
          cnt_nxt   = CNT_W'(1);
        end
      end
      LOCK: begin
        win_c = owner;
        // A stalled register freezes the lock; nobody else can cut in.
        if (free_c) begin
          if (req[owner]) begin
            grant_c = 1'b1;
            if (burst_cnt + CNT_W'(1) == CNT_W'(BURST_LEN)) begin
              state_nxt = IDLE;
              ptr_nxt   = next_of(owner);
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = burst_cnt + CNT_W'(1);
            end
          end else begin
            state_nxt = IDLE;
            ptr_nxt   = next_of(owner);
            cnt_nxt   = '0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
`else
    if (free_c && rr_hit_c) begin
      grant_c = 1'b1;
      ptr_nxt = next_of(rr_win_c);
    end
`endif
  end

  // Beat mux for the selected requester.
  always_comb begin
    beat_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_c == PTR_W'(i)) beat_c = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Grant strobe and next value of the output register.
  always_comb begin
    gnt         = '0;
    w_valid_nxt = w_valid;
    w_data_nxt  = w_data;
    if (grant_c) begin
      gnt[win_c]  = 1'b1;
      w_valid_nxt = 1'b1;
      w_data_nxt  = beat_c;
    end else if (!full) begin
      w_valid_nxt = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      w_valid <= 1'b0;
      w_data  <= '0;
`ifdef FIFO_ARB_BURST_EN
      state     <= IDLE;
      owner     <= '0;
      burst_cnt <= '0;
`endif
    end else begin
      ptr     <= ptr_nxt;
      w_valid <= w_valid_nxt;
      w_data  <= w_data_nxt;
`ifdef FIFO_ARB_BURST_EN
      state     <= state_nxt;
      owner     <= owner_nxt;
      burst_cnt <= cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Testbench for fifo_wr_arb (NREQ=4, DATA_W=8, BURST_LEN=4).
// A reference model predicts gnt each cycle; predicted beats go into a
// scoreboard queue and are popped when the FIFO consumes w_data.

module tb_fifo_wr_arb;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int BL   = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0] gnt;
  logic            full;
  logic            w_valid;
  logic [DW-1:0]   w_data;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sb_q[$];

  // Reference model state
  int   ptr_m;
  logic vm;
  bit   lock_m;
  int   own_m;
  int   cnt_m;

  fifo_wr_arb #(.NREQ(NREQ), .DATA_W(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .gnt(gnt), .full(full), .w_valid(w_valid), .w_data(w_data)
  );

  always #5 clk = ~clk;

  function automatic int idx_of(input logic [NREQ-1:0] g);
    for (int i = 0; i < NREQ; i++) if (g[i]) return i;
    return 0;
  endfunction

  function automatic logic [NREQ-1:0] model_gnt();
    logic [NREQ-1:0] g;
    int idx;
    g = '0;
    if (!rst_n) return g;
    if (vm && full) return g;
`ifdef FIFO_ARB_BURST_EN
    if (lock_m) begin
      if (req[own_m]) g[own_m] = 1'b1;
      return g;
    end
`endif
    for (int k = 0; k < NREQ; k++) begin
      idx = (ptr_m + k) % NREQ;
      if (req[idx]) begin
        g[idx] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  // Advance the model across one clock edge given the grant of this cycle.
  function automatic void model_adv(input logic [NREQ-1:0] g);
    bit fr;
    int w;
    fr = !vm || !full;
    w  = idx_of(g);
    if (g != 0) vm = 1'b1;
    else if (!full) vm = 1'b0;
`ifdef FIFO_ARB_BURST_EN
    if (!lock_m) begin
      if (g != 0) begin
        lock_m = 1'b1; own_m = w; cnt_m = 1; ptr_m = (w + 1) % NREQ;
      end
    end else if (g != 0) begin
      cnt_m++;
      if (cnt_m == BL) begin
        lock_m = 1'b0; cnt_m = 0; ptr_m = (own_m + 1) % NREQ;
      end
    end else if (fr && !req[own_m]) begin
      lock_m = 1'b0; cnt_m = 0; ptr_m = (own_m + 1) % NREQ;
    end
`else
    if (g != 0) ptr_m = (w + 1) % NREQ;
`endif
  endfunction

  function automatic void model_reset();
    ptr_m = 0; vm = 1'b0; lock_m = 1'b0; own_m = 0; cnt_m = 0;
    sb_q.delete();
  endfunction

  function automatic void push_beat(input logic [NREQ-1:0] g);
    if (g != 0) sb_q.push_back(req_data[idx_of(g)*DW +: DW]);
  endfunction

  // Consumption monitor: each beat leaving the register must match the queue head.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && w_valid === 1'b1 && full === 1'b0) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got w_data %h, expected no write", w_data);
      end else begin
        logic [DW-1:0] e;
        e = sb_q.pop_front();
        if (w_data !== e) begin
          errors++;
          $display("FAIL sb_data: got %h expected %h", w_data, e);
        end
      end
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0; req = '0; full = 1'b0; req_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    req = '0; full = 1'b0;
    repeat (n) begin
      @(negedge clk);
      model_adv(model_gnt());
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    req = 4'hF; full = 1'b0; req_data = 32'h4433_2211;
    #2;
    checks++; if (w_valid !== 1'b0) begin errors++; $display("FAIL reset_wvalid: got %b expected 0", w_valid); end
    checks++; if (w_data !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %h expected 00", w_data); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (gnt !== 4'b0000 || w_valid !== 1'b0) begin
      errors++; $display("FAIL reset_hold: got gnt %b w_valid %b expected 0000 0", gnt, w_valid);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL reset_first_gnt: got %b expected 0001", gnt); end
    push_beat(4'b0001); model_adv(4'b0001);
    @(posedge clk); #1;
    checks++; if (w_valid !== 1'b1 || w_data !== 8'h11) begin
      errors++; $display("FAIL reset_first_beat: got %b/%h expected 1/11", w_valid, w_data);
    end
    idle_cycles(2);
  endtask

  task automatic test_single();
    apply_reset();
    req = 4'b0001; req_data = 32'h0000_00A5; full = 1'b0;
    @(negedge clk);
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b expected 0001", gnt); end
    push_beat(4'b0001); model_adv(4'b0001);
    @(posedge clk); #1 req = '0;
    @(negedge clk);
    checks++; if (w_valid !== 1'b1 || w_data !== 8'hA5) begin
      errors++; $display("FAIL single_out: got %b/%h expected 1/a5", w_valid, w_data);
    end
    model_adv(model_gnt());
    @(posedge clk); #1;
    idle_cycles(2);
  endtask

`ifndef FIFO_ARB_BURST_EN
  task automatic test_round_robin();
    logic [NREQ-1:0] tbl [5];
    tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    apply_reset();
    req = 4'b1111; req_data = 32'hD4C3_B2A1; full = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (gnt !== tbl[i]) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, gnt, tbl[i]); end
      push_beat(tbl[i]); model_adv(tbl[i]);
      @(posedge clk); #1;
    end
    idle_cycles(2);
  endtask
`endif

  task automatic test_full_stall();
    apply_reset();
    req = 4'b0010; req_data = 32'h0000_3C00; full = 1'b0;
    @(negedge clk);
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL stall_first_gnt: got %b expected 0010", gnt); end
    push_beat(4'b0010); model_adv(4'b0010);
    @(posedge clk); #1 full = 1'b1; req_data = 32'h0000_7700;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (gnt !== 4'b0000 || w_valid !== 1'b1 || w_data !== 8'h3C) begin
        errors++; $display("FAIL stall[%0d]: got gnt %b out %b/%h expected 0000 1/3c", i, gnt, w_valid, w_data);
      end
      model_adv(4'b0000);
      @(posedge clk); #1;
    end
    full = 1'b0;
    @(negedge clk);
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL stall_release_gnt: got %b expected 0010", gnt); end
    push_beat(4'b0010); model_adv(4'b0010);
    @(posedge clk); #1;
    idle_cycles(2);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req = 4'b0100; req_data = 32'h005A_0000; full = 1'b0;
    @(negedge clk);
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL mid_pre_gnt: got %b expected 0100", gnt); end
    push_beat(4'b0100); model_adv(4'b0100);
    @(posedge clk); #1 full = 1'b1; req = '0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (w_valid !== 1'b0 || w_data !== 8'h00 || gnt !== 4'b0000) begin
      errors++; $display("FAIL mid_async: got %b/%h gnt %b expected 0/00 0000", w_valid, w_data, gnt);
    end
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    req = 4'b1010; req_data = 32'hE3E2_E1E0; full = 1'b0;
    @(negedge clk);
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL mid_post_gnt: got %b expected 0010", gnt); end
    push_beat(4'b0010); model_adv(4'b0010);
    @(posedge clk); #1 req = '0;
    @(negedge clk);
    checks++; if (w_valid !== 1'b1 || w_data !== 8'hE1) begin
      errors++; $display("FAIL mid_post_beat: got %b/%h expected 1/e1", w_valid, w_data);
    end
    model_adv(model_gnt());
    @(posedge clk); #1;
    idle_cycles(2);
  endtask

`ifdef FIFO_ARB_BURST_EN
  task automatic test_burst_lock();
    logic [NREQ-1:0] e;
    apply_reset();
    req = 4'b0011; req_data = 32'h0000_B2A1; full = 1'b0;
    for (int i = 0; i < 12; i++) begin
      e = (i < 4) ? 4'b0001 : (i < 8) ? 4'b0010 : 4'b0001;
      @(negedge clk);
      checks++; if (gnt !== e) begin errors++; $display("FAIL burst_gnt[%0d]: got %b expected %b", i, gnt, e); end
      push_beat(e); model_adv(e);
      @(posedge clk); #1;
    end
    idle_cycles(2);
  endtask

  task automatic test_burst_drop();
    logic [NREQ-1:0] got, e;
    apply_reset();
    req = 4'b0100; req_data = 32'h9988_7766; full = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL drop_owner[%0d]: got %b expected 0100", i, gnt); end
      push_beat(4'b0100); model_adv(4'b0100);
      @(posedge clk); #1;
    end
    req = 4'b1000;
    got = '0;
    for (int i = 0; i < 4 && got == 0; i++) begin
      @(negedge clk);
      e = model_gnt();
      got = gnt;
      checks++; if (gnt !== e) begin errors++; $display("FAIL drop_cycle[%0d]: got %b expected %b", i, gnt, e); end
      push_beat(e); model_adv(e);
      @(posedge clk); #1;
    end
    checks++; if (got !== 4'b1000) begin errors++; $display("FAIL drop_next_gnt: got %b expected 1000", got); end
    idle_cycles(3);
  endtask
`endif

  task automatic test_random();
    logic [NREQ-1:0] e;
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      req      = NREQ'($urandom);
      full     = ($urandom_range(0, 3) == 0);
      req_data = $urandom;
      @(negedge clk);
      e = model_gnt();
      checks++; if (gnt !== e) begin errors++; $display("FAIL rand_gnt[%0d]: got %b expected %b", i, gnt, e); end
      push_beat(e); model_adv(e);
      @(posedge clk); #1;
    end
    idle_cycles(3);
  endtask

  initial begin
    rst_n = 1'b1; req = '0; full = 1'b0; req_data = '0;
    model_reset();
    test_reset();
    test_single();
`ifndef FIFO_ARB_BURST_EN
    test_round_robin();
`else
    test_burst_lock();
    test_burst_drop();
`endif
    test_full_stall();
    test_reset_mid();
    test_random();
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL sb_drain: got %0d beats left expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
